// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and helpers for the MEM/WB stage: write-enable levels,
// stall-vector bit positions and the per-edge pipeline action.
package mem_wb_stage_pkg;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam int   REG_NUM_LOG2  = 5;
  localparam int   STALL_MEM     = 4;
  localparam int   STALL_WB      = 5;

  typedef enum logic [1:0] {
    ACT_CAPTURE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2
  } wb_action_e;

  // Flush beats stall; a stalled MEM with a running WB must inject a bubble.
  function automatic wb_action_e wb_action(input logic flush,
                                           input logic stall_mem,
                                           input logic stall_wb);
    if (flush)
      return ACT_BUBBLE;
    if (stall_mem && !stall_wb)
      return ACT_BUBBLE;
    if (stall_mem)
      return ACT_HOLD;
    return ACT_CAPTURE;
  endfunction

endpackage

// File: rtl/mem_wb_stage_hilo_llbit_regs.sv
// Architectural HI/LO registers and the LLbit used by LL/SC, written from
// the WB-stage entry of the MEM/WB pipeline register.
module hilo_llbit_regs
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  input  logic              llbit_we,
  input  logic              llbit_value,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              llbit_o
);

  logic llbit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (whilo == WRITE_ENABLE) begin
      hi_o <= hi;
      lo_o <= lo;
    end
  end

  // An exception kills any reservation, even one being written this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      llbit_q <= 1'b0;
    else if (flush)
      llbit_q <= 1'b0;
    else if (llbit_we == WRITE_ENABLE)
      llbit_q <= llbit_value;
  end

  always_comb begin
    llbit_o = llbit_q;
    if (flush)
      llbit_o = 1'b0;
    else if (llbit_we == WRITE_ENABLE)
      llbit_o = llbit_value;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: drives the regfile write port, exports the
// WB-stage HI/LO write for forwarding, and owns HI/LO and LLbit state.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = REG_NUM_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              mem_llbit_we,
  input  logic              mem_llbit_value,
  output logic [REG_AW-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              llbit_o
);

  wb_action_e action;
  logic       wb_llbit_we;
  logic       wb_llbit_value;
  logic       stall_unused;

  // Lower stall bits steer the earlier stages and are not needed here.
  assign stall_unused = ^stall[3:0];

  assign action = wb_action(flush, stall[STALL_MEM], stall[STALL_WB]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_wd          <= '0;
      wb_wreg        <= WRITE_DISABLE;
      wb_wdata       <= '0;
      wb_whilo       <= WRITE_DISABLE;
      wb_hi          <= '0;
      wb_lo          <= '0;
      wb_llbit_we    <= WRITE_DISABLE;
      wb_llbit_value <= 1'b0;
    end else begin
      case (action)
        ACT_CAPTURE: begin
          wb_wd          <= mem_wd;
          wb_wreg        <= mem_wreg;
          wb_wdata       <= mem_wdata;
          wb_whilo       <= mem_whilo;
          wb_hi          <= mem_hi;
          wb_lo          <= mem_lo;
          wb_llbit_we    <= mem_llbit_we;
          wb_llbit_value <= mem_llbit_value;
        end
        ACT_BUBBLE: begin
          wb_wd          <= '0;
          wb_wreg        <= WRITE_DISABLE;
          wb_wdata       <= '0;
          wb_whilo       <= WRITE_DISABLE;
          wb_hi          <= '0;
          wb_lo          <= '0;
          wb_llbit_we    <= WRITE_DISABLE;
          wb_llbit_value <= 1'b0;
        end
        default: begin
          wb_wd          <= wb_wd;
          wb_wreg        <= wb_wreg;
          wb_wdata       <= wb_wdata;
          wb_whilo       <= wb_whilo;
          wb_hi          <= wb_hi;
          wb_lo          <= wb_lo;
          wb_llbit_we    <= wb_llbit_we;
          wb_llbit_value <= wb_llbit_value;
        end
      endcase
    end
  end

  hilo_llbit_regs #(
    .DATA_W(DATA_W)
  ) u_regs (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .whilo      (wb_whilo),
    .hi         (wb_hi),
    .lo         (wb_lo),
    .llbit_we   (wb_llbit_we),
    .llbit_value(wb_llbit_value),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .llbit_o    (llbit_o)
  );

endmodule
